stoch_bitstream_decoder: RTL and testbench

//   Converts a stochastic bitstream back to a binary count over a programmable window.

---
 rtl/stoch_pkg.sv | 5 +
 rtl/stoch_bitstream_decoder_if.sv | 30 +++
 rtl/stoch_window_counter.sv | 26 ++
 rtl/stoch_bitstream_decoder.sv | 73 +++++++
 tb/tb_stoch_bitstream_decoder.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/stoch_pkg.sv
// stoch_pkg: shared state encoding and default width for the stochastic bitstream decoder
package stoch_pkg;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_OUTPUT} state_t;
endpackage

// File: rtl/stoch_bitstream_decoder_if.sv
// stoch_bitstream_decoder_if: window control, bit input and valid/ready result bundle
// out_bipolar exists only when STOCH_DEC_BIPOLAR_EN is defined
interface stoch_bitstream_decoder_if #(parameter int CNT_W = stoch_pkg::CNT_W_DEF);
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             bit_in;
    logic             bit_valid;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [CNT_W-1:0] out_len;
`ifdef STOCH_DEC_BIPOLAR_EN
    logic [CNT_W:0]   out_bipolar;
`endif
    modport master (
        output start, win_len, bit_in, bit_valid, out_ready,
        input  busy, out_valid, out_count, out_len
`ifdef STOCH_DEC_BIPOLAR_EN
        , out_bipolar
`endif
    );
    modport slave (
        input  start, win_len, bit_in, bit_valid, out_ready,
        output busy, out_valid, out_count, out_len
`ifdef STOCH_DEC_BIPOLAR_EN
        , out_bipolar
`endif
    );
endinterface

// File: rtl/stoch_window_counter.sv
// stoch_window_counter: ones up-counter and remaining-bits down-counter for one window
module stoch_window_counter #(parameter int CNT_W = 16) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] ones,
    output logic             last
);
    logic [CNT_W-1:0] rem;
    assign last = rem == CNT_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            ones <= '0;
            rem  <= '0;
        end else if (load) begin
            ones <= '0;
            rem  <= len;
        end else if (en) begin
            ones <= ones + CNT_W'(bit_in);
            rem  <= rem - CNT_W'(1);
        end
    end
endmodule

// File: rtl/stoch_bitstream_decoder.sv
// stoch_bitstream_decoder: counts ones over a programmable window, result on valid/ready
// Optional STOCH_DEC_BIPOLAR_EN adds out_bipolar = 2*out_count - out_len
module stoch_bitstream_decoder
    import stoch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input logic                     clk,
    input logic                     rst,
    stoch_bitstream_decoder_if.slave io
);
    state_t           state, state_nx;
    logic             load, en, cap, last, start_ok;
    logic [CNT_W-1:0] ones, len_q, count_nx;
    assign start_ok     = io.start && (io.win_len != '0);
    assign count_nx     = ones + CNT_W'(io.bit_in);
    assign io.busy      = state == ST_ACCUM;
    assign io.out_valid = state == ST_OUTPUT;
    stoch_window_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .len    (io.win_len),
        .en     (en),
        .bit_in (io.bit_in),
        .ones   (ones),
        .last   (last)
    );
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        en       = 1'b0;
        cap      = 1'b0;
        case (state)
            ST_IDLE: begin
                load     = start_ok;
                state_nx = start_ok ? ST_ACCUM : ST_IDLE;
            end
            ST_ACCUM: begin
                en       = io.bit_valid;
                cap      = io.bit_valid && last;
                state_nx = cap ? ST_OUTPUT : ST_ACCUM;
            end
            ST_OUTPUT: begin
                // back-to-back window: a start on the handshake cycle skips IDLE
                load     = io.out_ready && start_ok;
                state_nx = load ? ST_ACCUM : (io.out_ready ? ST_IDLE : ST_OUTPUT);
            end
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            io.out_count <= '0;
            io.out_len   <= '0;
        end else begin
            state <= state_nx;
            if (load) len_q <= io.win_len;
            if (cap) begin
                io.out_count <= count_nx;
                io.out_len   <= len_q;
            end
        end
    end
`ifdef STOCH_DEC_BIPOLAR_EN
    always_ff @(posedge clk) begin
        if (rst) io.out_bipolar <= '0;
        else if (cap) io.out_bipolar <= {count_nx, 1'b0} - {1'b0, len_q};
    end
`endif
endmodule

// File: tb/tb_stoch_bitstream_decoder.sv
// tb_stoch_bitstream_decoder: directed checks of windowing, stalls, backpressure, reset, limits
module tb_stoch_bitstream_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] pat1 = 8'b0100_1101;
    always #5 clk = ~clk;
    stoch_bitstream_decoder_if #(.CNT_W(16)) io ();
    stoch_bitstream_decoder_if #(.CNT_W(4))  io4 ();
    stoch_bitstream_decoder #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .io(io.slave));
    stoch_bitstream_decoder #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .io(io4.slave));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic s, input logic [15:0] wl, input logic b, input logic v, input logic r);
        io.start     = s;
        io.win_len   = wl;
        io.bit_in    = b;
        io.bit_valid = v;
        io.out_ready = r;
    endtask
    task automatic drive4(input logic s, input logic [3:0] wl, input logic b, input logic v, input logic r);
        io4.start     = s;
        io4.win_len   = wl;
        io4.bit_in    = b;
        io4.bit_valid = v;
        io4.out_ready = r;
    endtask
    initial begin
        drive(0, 0, 0, 0, 0);
        drive4(0, 0, 0, 0, 0);
        tick;
        tick;
        check("rst_busy", io.busy, 0);
        check("rst_valid", io.out_valid, 0);
        check("rst_count", io.out_count, 0);
        check("rst_len", io.out_len, 0);
`ifdef STOCH_DEC_BIPOLAR_EN
        check("rst_bip", 32'($signed(io.out_bipolar)), 0);
`endif
        rst = 1'b0;
        // case 1: bit offered in the start cycle must not be counted
        drive(1, 8, 1, 1, 0);
        tick;
        check("t1_busy", io.busy, 1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, pat1[i], 1, 0);
            tick;
            if (i == 6) check("t1_early", io.out_valid, 0);
        end
        check("t1_valid", io.out_valid, 1);
        check("t1_busy_end", io.busy, 0);
        check("t1_count", io.out_count, 4);
        check("t1_len", io.out_len, 8);
`ifdef STOCH_DEC_BIPOLAR_EN
        check("t1_bip", 32'($signed(io.out_bipolar)), 0);
`endif
        drive(0, 0, 0, 0, 1);
        tick;
        check("t1_hs_valid", io.out_valid, 0);
        check("t1_hold_count", io.out_count, 4);
        // case 2: 16 ones with a 3-cycle stall after the 8th bit
        drive(1, 16, 0, 0, 0);
        tick;
        for (int c = 1; c <= 19; c++) begin
            drive(0, 0, 1, !(c >= 9 && c <= 11), 0);
            tick;
            if (c == 10) check("t2_stall_busy", io.busy, 1);
            if (c == 18) check("t2_early", io.out_valid, 0);
        end
        check("t2_valid", io.out_valid, 1);
        check("t2_count", io.out_count, 16);
        check("t2_len", io.out_len, 16);
        // case 3: backpressure, start pulses and bits ignored
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 4, 1, 1, 0);
            tick;
            check("t3_valid", io.out_valid, 1);
            check("t3_count", io.out_count, 16);
            check("t3_busy", io.busy, 0);
        end
        // case 4: start on the handshake cycle
        drive(1, 4, 0, 1, 1);
        tick;
        check("t4_busy", io.busy, 1);
        check("t4_valid", io.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, 0);
            tick;
        end
        check("t4_valid_end", io.out_valid, 1);
        check("t4_count", io.out_count, 4);
        check("t4_len", io.out_len, 4);
`ifdef STOCH_DEC_BIPOLAR_EN
        check("t4_bip", 32'($signed(io.out_bipolar)), 4);
`endif
        drive(0, 0, 0, 0, 1);
        tick;
        // case 5: reset mid-window discards the partial count
        drive(1, 8, 0, 0, 0);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0);
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("t5_busy", io.busy, 0);
        check("t5_valid", io.out_valid, 0);
        check("t5_count", io.out_count, 0);
        check("t5_len", io.out_len, 0);
        drive(1, 2, 0, 0, 0);
        tick;
        drive(0, 0, 1, 1, 0);
        tick;
        tick;
        check("t5_valid_end", io.out_valid, 1);
        check("t5_count_end", io.out_count, 2);
        drive(0, 0, 0, 0, 1);
        tick;
        // case 6: zero-length start ignored, then the maximum window of ones
        drive(1, 0, 1, 1, 0);
        tick;
        check("t6_zero_busy", io.busy, 0);
        check("t6_zero_valid", io.out_valid, 0);
        drive(1, 16'hffff, 0, 0, 0);
        tick;
        drive(0, 0, 1, 1, 0);
        repeat (65535) tick;
        check("t6_max_valid", io.out_valid, 1);
        check("t6_max_count", io.out_count, 65535);
        check("t6_max_len", io.out_len, 65535);
`ifdef STOCH_DEC_BIPOLAR_EN
        check("t6_max_bip", 32'($signed(io.out_bipolar)), 65535);
`endif
        drive(0, 0, 0, 0, 1);
        tick;
        // narrow instance: full-scale ones and zeros at CNT_W=4
        drive4(1, 15, 0, 0, 0);
        tick;
        drive4(0, 0, 1, 1, 0);
        repeat (15) tick;
        check("n_ones_valid", io4.out_valid, 1);
        check("n_ones_count", io4.out_count, 15);
`ifdef STOCH_DEC_BIPOLAR_EN
        check("n_ones_bip", 32'($signed(io4.out_bipolar)), 15);
`endif
        drive4(1, 15, 0, 0, 1);
        tick;
        check("n_b2b_busy", io4.busy, 1);
        drive4(0, 0, 0, 1, 0);
        repeat (15) tick;
        check("n_zeros_valid", io4.out_valid, 1);
        check("n_zeros_count", io4.out_count, 0);
        check("n_zeros_len", io4.out_len, 15);
`ifdef STOCH_DEC_BIPOLAR_EN
        check("n_zeros_bip", 32'($signed(io4.out_bipolar)), 32'(-15));
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
